cacheline_burst_adaptor: RTL and testbench
==========================================

Name: cacheline_burst_adaptor

Overview:
- Memory-side responder for the LLC cache datapath.
- Accepts single 256-bit cacheline read and write requests from the cache's pmem port.
- Converts each request into a 4-beat, 64-bit burst transaction on the physical memory bus.
- Returns one full line with a single-cycle response pulse to the cache.

Parameters:
s_line, 256, cacheline width in bits (cache side)
s_burst, 64, memory bus beat width in bits
num_beats, s_line/s_burst (=4), beats per line transfer
s_offset, 5, byte-offset bits cleared when aligning the address

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-high reset
pmem_address  input  32  line request address from cache
pmem_read  input  1  line read request; held high until pmem_resp
pmem_write  input  1  line write request; held high until pmem_resp
pmem_wdata  input  256  line write data; valid while pmem_write is high
pmem_rdata  output  256  assembled read line
pmem_resp  output  1  one-cycle completion pulse to cache
mem_address  output  32  line-aligned burst address
mem_read  output  1  burst read request to memory
mem_write  output  1  burst write request to memory
mem_wdata  output  64  current write beat
mem_rdata  input  64  current read beat; sampled when mem_resp is high
mem_resp  input  1  beat handshake from memory; one beat per high cycle

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state = IDLE, beat counter = 0.
  - pmem_resp, mem_read, mem_write = 0.
  - mem_address, mem_wdata, pmem_rdata = 0.
  - Internal line buffer cleared.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - On a clock edge with pmem_read=1, latch {pmem_address[31:s_offset], 5'b0} into mem_address, clear the counter, go to RD_BURST.
  - Else on a clock edge with pmem_write=1, latch the same aligned address and latch pmem_wdata into the line buffer, go to WR_BURST.
  - pmem_read and pmem_write both high is illegal; read wins, and the write is not performed.
- RD_BURST:
  - mem_read=1 for the whole state.
  - On each edge with mem_resp=1, store mem_rdata into line-buffer beat[counter] and increment the counter.
  - Beat 0 maps to bits [63:0]; beat 3 maps to [255:192].
  - mem_resp low cycles (gaps) are legal: no store, counter holds.
  - On the edge that captures beat num_beats-1, go to DONE. mem_read drops in the DONE cycle.
- WR_BURST:
  - mem_write=1 for the whole state; mem_wdata = line-buffer beat[counter] combinationally.
  - On each edge with mem_resp=1, increment the counter. Gaps hold mem_wdata stable.
  - On the edge consuming the last beat, go to DONE.
- DONE:
  - pmem_resp=1 for exactly one cycle, then unconditionally go to IDLE.
  - For reads, pmem_rdata equals the full line registered at the DONE cycle. It holds until the next read completes; writes do not modify it.
  - The cache deasserts its request in the cycle after pmem_resp. IDLE never sees a stale request, so no double acceptance occurs.
- mem_address is stable from the first mem_read/mem_write cycle through the last beat and holds afterwards.
- Counter width is clog2(num_beats). Wrap to 0 is irrelevant because the counter is cleared on acceptance.
- Latency: request seen at edge E0 → mem_read/mem_write high in cycle E0+1. With 4 back-to-back mem_resp beats starting at cycle E0+1+k, pmem_resp is high in cycle E0+5+k.
- Minimum line turnaround is 6 cycles, including the IDLE cycle.
- mem_resp while in IDLE or DONE is ignored.
- Reset asserted mid-burst aborts immediately: partial beats are discarded, no pmem_resp is issued, and the next request starts fresh.

Test Plan:
- Read, pmem_address=0x0000_1234, memory returns beats 0x1111…, 0x2222…, 0x3333…, 0x4444… on consecutive cycles → mem_address=0x0000_1220; pmem_rdata={0x4444…,0x3333…,0x2222…,0x1111…}; single pmem_resp pulse 5 cycles after request edge.
- Write, pmem_wdata = beats A,B,C,D from LSB, mem_resp high 4 consecutive cycles → mem_wdata sequence A,B,C,D; mem_write high exactly 4 cycles; pmem_resp once; pmem_rdata unchanged.
- Read with mem_resp pattern 1,0,0,1,1,0,1 → 4 beats captured in order; pmem_resp 1 cycle after the 7th cycle; mem_address stable throughout.
- Writeback of line 0x0000_0040, then read of 0x0000_0080 issued the cycle after pmem_resp → two independent bursts; correct addresses; no dropped or duplicated beats.
- rst asserted after 2 read beats → outputs 0 asynchronously, no pmem_resp; subsequent read of 0x100 completes normally with fresh data.
- pmem_read and pmem_write both high → only a read burst occurs; mem_write never asserts.

Source files
------------

// File: rtl/cacheline_burst_adaptor.sv
// Bridges single 256-bit cacheline requests to 4-beat 64-bit memory bursts
// and returns the assembled line with a one-cycle completion pulse.
module cacheline_burst_adaptor (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic [31:0]  mem_address,
  output logic         mem_read,
  output logic         mem_write,
  output logic [63:0]  mem_wdata,
  input  logic [63:0]  mem_rdata,
  input  logic         mem_resp
);

  localparam int unsigned S_LINE    = 256;
  localparam int unsigned S_BURST   = 64;
  localparam int unsigned NUM_BEATS = S_LINE / S_BURST;
  localparam int unsigned S_OFFSET  = 5;
  localparam int unsigned CNT_W     = $clog2(NUM_BEATS);
  localparam logic [31:0] ALIGN_MASK = 32'((64'd1 << S_OFFSET) - 64'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [31:0]                         addr_q, addr_d;
  logic [NUM_BEATS-1:0][S_BURST-1:0]   line_q, line_d;
  logic [S_LINE-1:0]                   rdata_q, rdata_d;
  logic                                resp_q, resp_d;
  logic                                rd_q, rd_d;
  logic                                wr_q, wr_d;
  logic                                last_beat;

  assign last_beat = (cnt_q == CNT_W'(NUM_BEATS - 1));

  // Next-state, beat capture and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (pmem_read) begin
          addr_d  = pmem_address & ~ALIGN_MASK;
          cnt_d   = '0;
          state_d = RD_BURST;
        end else if (pmem_write) begin
          addr_d  = pmem_address & ~ALIGN_MASK;
          line_d  = pmem_wdata;
          cnt_d   = '0;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          line_d[cnt_q] = mem_rdata;
          cnt_d         = cnt_q + CNT_W'(1);
          if (last_beat) begin
            rdata_d = line_d;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (mem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs track the state being entered so they are flop-driven
    rd_d   = (state_d == RD_BURST);
    wr_d   = (state_d == WR_BURST);
    resp_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = resp_q;
  assign mem_address = addr_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  // Current write beat selected straight from the line buffer
  assign mem_wdata   = line_q[cnt_q];

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Scoreboard bench for cacheline_burst_adaptor: a behavioural memory answers
// bursts while per-scenario tasks compare captured traffic with expectations.
module tb_cacheline_burst_adaptor;

  logic         clk;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  cacheline_burst_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [255:0] exp_line_q[$];
  logic [255:0] obs_line_q[$];
  logic [63:0]  exp_beat_q[$];
  logic [63:0]  obs_beat_q[$];

  logic [31:0]  obs_addr;
  int           addr_unstable, rd_cycles, wr_cycles, resp_cyc, resp_count;
  bit           timed_out;
  logic [255:0] last_read_line;

  // Behavioural memory plus cache-side driver for one line transaction
  task automatic run_burst(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wline, input logic [255:0] rline,
                           input logic [15:0] pat, input int plen, input int tail);
    int pi, bi;
    bit seen;
    addr_unstable = 0; rd_cycles = 0; wr_cycles = 0; resp_cyc = -1; resp_count = 0;
    timed_out = 0; seen = 0; pi = 0; bi = 0; obs_addr = 'x;
    @(negedge clk);
    pmem_address = addr; pmem_read = rd; pmem_write = wr; pmem_wdata = wline;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      if (mem_read || mem_write) begin
        if (!seen) begin
          obs_addr = mem_address;
          seen = 1;
        end else if (mem_address !== obs_addr) begin
          addr_unstable++;
        end
        if (mem_read) rd_cycles++;
        if (mem_write) wr_cycles++;
        mem_resp = (pi < plen) ? pat[pi] : 1'b1;
        pi++;
        if (mem_resp && mem_read) begin
          mem_rdata = rline[(bi % 4) * 64 +: 64];
          bi++;
        end
        if (mem_resp && mem_write) obs_beat_q.push_back(mem_wdata);
      end
      if (pmem_resp) begin
        resp_count++;
        if (resp_cyc < 0) begin
          resp_cyc = cyc;
          obs_line_q.push_back(pmem_rdata);
          if (tail > 0) begin
            pmem_read = 1'b0; pmem_write = 1'b0;
          end
        end
      end
      if (resp_cyc >= 0 && cyc >= resp_cyc + tail) break;
    end
    if (resp_cyc < 0) timed_out = 1;
    if (tail > 0 || timed_out) begin
      pmem_read = 1'b0; pmem_write = 1'b0;
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h wdata=%h rdata=%h, want all 0",
               pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    logic [255:0] line, got;
    line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    exp_line_q.push_back(line);
    run_burst(1'b1, 1'b0, 32'h0000_1234, '0, line, 16'h0, 0, 2);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL read_basic_timeout: no pmem_resp within budget"); end
    n_cmp++;
    if (obs_addr !== 32'h0000_1220) begin
      n_bad++; $display("FAIL read_basic_addr: got %h want 00001220", obs_addr);
    end
    got = (obs_line_q.size() > 0) ? obs_line_q.pop_front() : 'x;
    line = exp_line_q.pop_front();
    n_cmp++;
    if (got !== line) begin n_bad++; $display("FAIL read_basic_rdata: got %h want %h", got, line); end
    n_cmp++;
    if (resp_cyc !== 5) begin n_bad++; $display("FAIL read_basic_latency: got %0d want 5", resp_cyc); end
    n_cmp++;
    if (resp_count !== 1) begin n_bad++; $display("FAIL read_basic_resp_count: got %0d want 1", resp_count); end
    n_cmp++;
    if (rd_cycles !== 4) begin n_bad++; $display("FAIL read_basic_rd_cycles: got %0d want 4", rd_cycles); end
    last_read_line = line;
  endtask

  task automatic test_write();
    logic [63:0] b[4];
    logic [63:0] e, g;
    b[0] = 64'hAAAA_0000_AAAA_0001; b[1] = 64'hBBBB_0000_BBBB_0002;
    b[2] = 64'hCCCC_0000_CCCC_0003; b[3] = 64'hDDDD_0000_DDDD_0004;
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(b[i]);
    run_burst(1'b0, 1'b1, 32'h0000_2000, {b[3], b[2], b[1], b[0]}, '0, 16'h0, 0, 2);
    n_cmp++;
    if (wr_cycles !== 4) begin n_bad++; $display("FAIL write_cycles: got %0d want 4", wr_cycles); end
    for (int i = 0; i < 4; i++) begin
      e = exp_beat_q.pop_front();
      g = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL write_beat%0d: got %h want %h", i, g, e); end
    end
    n_cmp++;
    if (resp_count !== 1) begin n_bad++; $display("FAIL write_resp_count: got %0d want 1", resp_count); end
    n_cmp++;
    if (pmem_rdata !== last_read_line) begin
      n_bad++; $display("FAIL write_rdata_kept: got %h want %h", pmem_rdata, last_read_line);
    end
    void'(obs_line_q.pop_front());
  endtask

  task automatic test_read_gaps();
    logic [255:0] line, got;
    line = {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
            64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A};
    exp_line_q.push_back(line);
    run_burst(1'b1, 1'b0, 32'h0000_3FFF, '0, line, 16'h0059, 7, 2);
    got  = (obs_line_q.size() > 0) ? obs_line_q.pop_front() : 'x;
    line = exp_line_q.pop_front();
    n_cmp++;
    if (got !== line) begin n_bad++; $display("FAIL gaps_rdata: got %h want %h", got, line); end
    n_cmp++;
    if (resp_cyc !== 8) begin n_bad++; $display("FAIL gaps_latency: got %0d want 8", resp_cyc); end
    n_cmp++;
    if (rd_cycles !== 7) begin n_bad++; $display("FAIL gaps_rd_cycles: got %0d want 7", rd_cycles); end
    n_cmp++;
    if (addr_unstable !== 0 || obs_addr !== 32'h0000_3FE0) begin
      n_bad++; $display("FAIL gaps_addr: got %h unstable=%0d want 00003fe0 unstable=0", obs_addr, addr_unstable);
    end
    last_read_line = line;
  endtask

  task automatic test_back_to_back();
    logic [255:0] line, got;
    logic [63:0] e, g;
    for (int i = 0; i < 4; i++) exp_beat_q.push_back(64'h5000_0000_0000_0000 | 64'(i));
    run_burst(1'b0, 1'b1, 32'h0000_0040,
              {64'h5000_0000_0000_0003, 64'h5000_0000_0000_0002,
               64'h5000_0000_0000_0001, 64'h5000_0000_0000_0000}, '0, 16'h0, 0, 0);
    n_cmp++;
    if (obs_addr !== 32'h0000_0040 || wr_cycles !== 4) begin
      n_bad++; $display("FAIL b2b_write: got addr=%h cycles=%0d want 00000040 4", obs_addr, wr_cycles);
    end
    void'(obs_line_q.pop_front());
    line = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
            64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
    exp_line_q.push_back(line);
    run_burst(1'b1, 1'b0, 32'h0000_0080, '0, line, 16'h0, 0, 2);
    for (int i = 0; i < 4; i++) begin
      e = exp_beat_q.pop_front();
      g = (obs_beat_q.size() > 0) ? obs_beat_q.pop_front() : 'x;
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL b2b_wbeat%0d: got %h want %h", i, g, e); end
    end
    n_cmp++;
    if (obs_addr !== 32'h0000_0080 || resp_cyc !== 5 || wr_cycles !== 0) begin
      n_bad++; $display("FAIL b2b_read: got addr=%h lat=%0d wr=%0d want 00000080 5 0", obs_addr, resp_cyc, wr_cycles);
    end
    got  = (obs_line_q.size() > 0) ? obs_line_q.pop_front() : 'x;
    line = exp_line_q.pop_front();
    n_cmp++;
    if (got !== line) begin n_bad++; $display("FAIL b2b_rdata: got %h want %h", got, line); end
  endtask

  task automatic test_rw_conflict();
    logic [255:0] line, got;
    line = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
            64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};
    exp_line_q.push_back(line);
    run_burst(1'b1, 1'b1, 32'h0000_0200, {4{64'hFFFF_FFFF_FFFF_FFFF}}, line, 16'h0, 0, 2);
    n_cmp++;
    if (wr_cycles !== 0 || obs_beat_q.size() !== 0 || rd_cycles !== 4) begin
      n_bad++; $display("FAIL conflict_bursts: got wr=%0d rd=%0d want wr=0 rd=4", wr_cycles, rd_cycles);
    end
    obs_beat_q.delete();
    got  = (obs_line_q.size() > 0) ? obs_line_q.pop_front() : 'x;
    line = exp_line_q.pop_front();
    n_cmp++;
    if (got !== line) begin n_bad++; $display("FAIL conflict_rdata: got %h want %h", got, line); end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] line, got;
    @(negedge clk);
    pmem_address = 32'h0000_1000; pmem_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mem_resp  = 1'b1;
      mem_rdata = 64'h9999_9999_0000_0000 | 64'(i);
    end
    @(negedge clk);
    mem_resp = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h, want all 0",
               pmem_resp, mem_read, mem_write, mem_address, pmem_rdata);
    end
    pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    line = {64'h0100_0000_0000_0004, 64'h0100_0000_0000_0003,
            64'h0100_0000_0000_0002, 64'h0100_0000_0000_0001};
    exp_line_q.push_back(line);
    run_burst(1'b1, 1'b0, 32'h0000_0100, '0, line, 16'h0, 0, 2);
    got  = (obs_line_q.size() > 0) ? obs_line_q.pop_front() : 'x;
    line = exp_line_q.pop_front();
    n_cmp++;
    if (got !== line) begin n_bad++; $display("FAIL midreset_rdata: got %h want %h", got, line); end
    n_cmp++;
    if (obs_addr !== 32'h0000_0100 || resp_cyc !== 5 || resp_count !== 1) begin
      n_bad++; $display("FAIL midreset_followup: got addr=%h lat=%0d resps=%0d want 00000100 5 1",
                        obs_addr, resp_cyc, resp_count);
    end
  endtask

  initial begin
    rst = 1'b1; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0; last_read_line = '0;
    test_reset();
    test_read_basic();
    test_write();
    test_read_gaps();
    test_back_to_back();
    test_rw_conflict();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
